mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The module SHALL have parameter CNT_W, default 4, giving the width of the element count and of the length input.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request to run one accumulation; sampled only in IDLE.
REQ-005 The module SHALL have port len, input, CNT_W bits: number of products to accumulate; captured on an accepted start.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the operand source presents an x/y pair.
REQ-007 The module SHALL have port in_ready, output, 1 bit: the sequencer accepts an operand pair.
REQ-008 The module SHALL have port ld_op, output, 1 bit: load enable for the x/y operand registers.
REQ-009 The module SHALL have port ld_prod, output, 1 bit: load enable for the product register.
REQ-010 The module SHALL have port ld_acc, output, 1 bit: load enable for the accumulator register.
REQ-011 The module SHALL have port acc_sel, output, 2 bits: select for the 3:1 8-bit accumulator-input mux (00 zero, 01 acc+product, 10 acc hold).
REQ-012 The module SHALL have port count, output, CNT_W bits: number of products accumulated so far.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-014 The module SHALL have port done, output, 1 bit: single-cycle pulse marking completion of a run.

Function
REQ-015 The FSM SHALL have the states IDLE, CLR, WAIT, MUL, ACC and DONE, with Moore outputs only, except ld_op.
REQ-016 IDLE: start=1 SHALL capture len into len_q and go to CLR; start=0 SHALL keep IDLE.
REQ-017 CLR: the FSM SHALL assert ld_acc=1 and acc_sel=00, and set count to 0; it SHALL go to DONE if len_q==0, otherwise to WAIT.
REQ-018 WAIT: the FSM SHALL assert in_ready=1 and set ld_op=in_valid (combinational); it SHALL go to MUL on in_valid=1, otherwise stay in WAIT indefinitely.
REQ-019 MUL: the FSM SHALL assert ld_prod=1 and go to ACC.
REQ-020 ACC: the FSM SHALL assert ld_acc=1 and acc_sel=01, and set count to count+1; it SHALL go to DONE if count+1==len_q, otherwise to WAIT.
REQ-021 DONE: the FSM SHALL assert done=1 for exactly one cycle and go to IDLE.
REQ-022 acc_sel SHALL be 10 in every state other than CLR and ACC.
REQ-023 in_ready, ld_op, ld_prod and ld_acc SHALL be 0 in every state not listed above for them.
REQ-024 busy SHALL be 1 in CLR, WAIT, MUL and ACC, and 0 in IDLE and DONE.
REQ-025 start SHALL be ignored outside IDLE, including in DONE; len changes after capture SHALL have no effect.
REQ-026 count SHALL hold its final value after DONE until the next CLR.
REQ-027 With in_valid held at 1, done SHALL assert 3*len_q+2 cycles after the accepted start edge; for len_q=0, 2 cycles.
REQ-028 Each WAIT stall cycle (in_valid=0) SHALL add exactly one cycle of latency.
REQ-029 The comparison count+1==len_q SHALL be done at CNT_W+1 bits so that len=2^CNT_W-1 completes without wrap; count SHALL never exceed len_q.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, len_q=0 and count=0.
REQ-031 rst_n=0 SHALL immediately force in_ready, ld_op, ld_prod, ld_acc, busy and done to 0, and acc_sel to 10.
REQ-032 Reset mid-run SHALL abandon the run with no done pulse.
REQ-033 After release of rst_n, the first accepted start SHALL be on the first rising edge with start=1.

Verification
REQ-034 The bench SHALL apply len=3 with in_valid=1 constantly, expecting ld_op 3 times, ld_prod 3 times, ld_acc 4 times (1 clear with acc_sel=00, 3 accumulates with acc_sel=01), count=3, and done 11 cycles after start.
REQ-035 The bench SHALL apply len=0, expecting CLR then DONE, done 2 cycles after start, no in_ready, and count=0.
REQ-036 The bench SHALL apply len=2 with in_valid held low for 4 cycles before the second pair, expecting in_ready high throughout the stall, ld_op only when in_valid=1, and done at 8+4=12 cycles.
REQ-037 The bench SHALL pulse start during WAIT and during DONE, and change len mid-run, expecting no effect on the run and done only for the original len.
REQ-038 The bench SHALL assert rst_n=0 asynchronously in MUL of a len=5 run, expecting all outputs reset before the next clk edge, no done, and a subsequent len=1 run completing in 5 cycles.
REQ-039 The bench SHALL run with CNT_W=4 and len=15, expecting count to reach 15 with no wrap, and done at 47 cycles.

Source files
------------

// File: rtl/mac_sequencer.sv
// Control sequencer for an 8-bit multiply-accumulate datapath: clears the
// accumulator, then runs len load/multiply/accumulate rounds over x/y pairs.
module mac_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_op,
  output logic             ld_prod,
  output logic             ld_acc,
  output logic [1:0]       acc_sel,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned EXT_W = CNT_W + 1;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_WAIT = 3'd2,
    S_MUL  = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   len_q;
  logic [EXT_W-1:0]   cnt_inc;
  logic               last_c;

  // Extra bit keeps len = 2^CNT_W-1 from wrapping in the terminal compare.
  assign cnt_inc = {1'b0, count} + EXT_W'(1);
  assign last_c  = (cnt_inc == {1'b0, len_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_CLR;
      S_CLR:  state_nxt = (len_q == '0) ? S_DONE : S_WAIT;
      S_WAIT: if (in_valid) state_nxt = S_MUL;
      S_MUL:  state_nxt = S_ACC;
      S_ACC:  state_nxt = last_c ? S_DONE : S_WAIT;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore decode of the state register; ld_op alone follows in_valid.
  always_comb begin
    in_ready = 1'b0;
    ld_op    = 1'b0;
    ld_prod  = 1'b0;
    ld_acc   = 1'b0;
    acc_sel  = SEL_HOLD;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_CLR: begin
        ld_acc  = 1'b1;
        acc_sel = SEL_ZERO;
        busy    = 1'b1;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        ld_op    = in_valid;
        busy     = 1'b1;
      end
      S_MUL: begin
        ld_prod = 1'b1;
        busy    = 1'b1;
      end
      S_ACC: begin
        ld_acc  = 1'b1;
        acc_sel = SEL_ADD;
        busy    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Run length is frozen at start acceptance; count holds after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      count <= '0;
    end else begin
      if (state == S_IDLE && start) len_q <= len;
      if (state == S_CLR)           count <= '0;
      else if (state == S_ACC)      count <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: table of runs plus reset corner case,
// with a scoreboard queue of expected completion latency and final count.
module tb_mac_sequencer;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, ld_op, ld_prod, ld_acc, busy, done;
  logic [1:0]       acc_sel;
  logic [CNT_W-1:0] count;

  mac_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .ld_op(ld_op), .ld_prod(ld_prod), .ld_acc(ld_acc),
    .acc_sel(acc_sel), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l;
    int stall_pair;
    int stall_n;
    bit disturb;
    int exp_op;
    int exp_prod;
    int exp_clr;
    int exp_add;
    int exp_ready;
  } vec_t;

  typedef struct {
    int lat;
    int cnt;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_ld_op"},    int'(ld_op),    0);
    chk({tag, "_ld_prod"},  int'(ld_prod),  0);
    chk({tag, "_ld_acc"},   int'(ld_acc),   0);
    chk({tag, "_acc_sel"},  int'(acc_sel),  2);
    chk({tag, "_busy"},     int'(busy),     0);
    chk({tag, "_done"},     int'(done),     0);
    chk({tag, "_count"},    int'(count),    0);
  endtask

  // One complete run: start issued at a negedge, outputs sampled every negedge.
  task automatic do_run(input string tag, input vec_t v);
    int  cyc = 0, n_op = 0, n_prod = 0, n_clr = 0, n_add = 0, n_ready = 0;
    int  bad_op = 0, bad_busy = 0, bad_sel = 0, stalls = 0, lat = -1;
    bit  seen_ready = 1'b0, fin = 1'b0;
    sb_t e;
    sb_q.push_back('{lat: 3 * v.l + 2 + v.stall_n, cnt: v.l});
    @(negedge clk);
    start    = 1'b1;
    len      = CNT_W'(v.l);
    in_valid = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (lat >= 0) begin
        chk({tag, "_done_width"}, int'(done), 0);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        chk({tag, "_count_hold"}, int'(count), v.l);
        fin = 1'b1;
      end else if (cyc > 200) begin
        chk({tag, "_timeout"}, cyc, 3 * v.l + 2 + v.stall_n);
        fin = 1'b1;
      end else begin
        if (ld_prod) n_prod++;
        if (ld_acc && acc_sel == 2'b00) n_clr++;
        else if (ld_acc && acc_sel == 2'b01) n_add++;
        else if (ld_acc || acc_sel != 2'b10) bad_sel++;
        if (done) begin
          lat = cyc;
          chk({tag, "_busy_in_done"}, int'(busy), 0);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_count"}, int'(count), e.cnt);
          end else chk({tag, "_sb_empty"}, 0, 1);
          if (v.disturb) start = 1'b1;
        end else if (!busy) bad_busy++;
        in_valid = 1'b0;
        if (in_ready) begin
          n_ready++;
          if (v.disturb && !seen_ready) begin
            start = 1'b1;
            len   = CNT_W'(v.l + 4);
          end
          seen_ready = 1'b1;
          if (n_op == v.stall_pair && stalls < v.stall_n) stalls++;
          else in_valid = 1'b1;
        end
        #1;
        if (ld_op !== (in_ready & in_valid)) bad_op++;
        if (ld_op) n_op++;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_n_ld_op"},   n_op,    v.exp_op);
    chk({tag, "_n_ld_prod"}, n_prod,  v.exp_prod);
    chk({tag, "_n_clr"},     n_clr,   v.exp_clr);
    chk({tag, "_n_add"},     n_add,   v.exp_add);
    chk({tag, "_n_ready"},   n_ready, v.exp_ready);
    chk({tag, "_bad_ld_op"}, bad_op,  0);
    chk({tag, "_bad_busy"},  bad_busy, 0);
    chk({tag, "_bad_sel"},   bad_sel, 0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v1;
    int   guard;
    int   done_seen;
    vecs[0] = '{l: 3,  stall_pair: 0, stall_n: 0, disturb: 1'b0, exp_op: 3,  exp_prod: 3,  exp_clr: 1, exp_add: 3,  exp_ready: 3};
    vecs[1] = '{l: 0,  stall_pair: 0, stall_n: 0, disturb: 1'b0, exp_op: 0,  exp_prod: 0,  exp_clr: 1, exp_add: 0,  exp_ready: 0};
    vecs[2] = '{l: 2,  stall_pair: 1, stall_n: 4, disturb: 1'b0, exp_op: 2,  exp_prod: 2,  exp_clr: 1, exp_add: 2,  exp_ready: 6};
    vecs[3] = '{l: 3,  stall_pair: 0, stall_n: 0, disturb: 1'b1, exp_op: 3,  exp_prod: 3,  exp_clr: 1, exp_add: 3,  exp_ready: 3};
    vecs[4] = '{l: 15, stall_pair: 0, stall_n: 0, disturb: 1'b0, exp_op: 15, exp_prod: 15, exp_clr: 1, exp_add: 15, exp_ready: 15};
    vecs[5] = '{l: 1,  stall_pair: 0, stall_n: 0, disturb: 1'b0, exp_op: 1,  exp_prod: 1,  exp_clr: 1, exp_add: 1,  exp_ready: 1};
    v1 = vecs[5];

    #2;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_run($sformatf("vec%0d_len%0d", i, vecs[i].l), vecs[i]);

    // Abandon a len=5 run with an asynchronous reset while in MUL.
    @(negedge clk);
    start    = 1'b1;
    len      = CNT_W'(5);
    in_valid = 1'b1;
    guard    = 0;
    @(negedge clk);
    start = 1'b0;
    while (!ld_prod && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_mul", int'(ld_prod), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("rst_no_done", done_seen, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    do_run("after_rst_len1", v1);

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
